// File: rtl/ring_phase_if.sv
// ring_phase_if: sample/report bundle between a ring-counter source (master)
// and the ring_phase_monitor checker (slave).
//   en          sample enable (master -> slave)
//   cnt_in      ring counter value (master -> slave)
//   clr_alarm   leave ALARM (master -> slave)
//   locked      state is LOCKED (slave -> master)
//   alarm       state is ALARM (slave -> master)
//   phase       bit index of the tracked reference value (slave -> master)
//   phase_valid LOCKING or LOCKED (slave -> master)
//   err_pulse   one-cycle pulse per bad sample in LOCKED (slave -> master)
//   err_count   saturating bad-sample count (slave -> master)
interface ring_phase_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 16
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             en;
  logic [WIDTH-1:0] cnt_in;
  logic             clr_alarm;
  logic             locked;
  logic             alarm;
  logic [PW-1:0]    phase;
  logic             phase_valid;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  modport master (
    output en, cnt_in, clr_alarm,
    input  locked, alarm, phase, phase_valid, err_pulse, err_count
  );

  modport slave (
    input  en, cnt_in, clr_alarm,
    output locked, alarm, phase, phase_valid, err_pulse, err_count
  );
endinterface

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot ring counter. Each enabled sample must
// be one-hot and equal to the previous reference rotated left by one. A
// SEARCH -> LOCKING -> LOCKED -> ALARM machine tracks the ring; in LOCKED the
// reference flywheels forward on bad samples so an isolated glitch costs one
// error only.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ring_phase_if.slave (en, cnt_in, clr_alarm in; status/errors out)
// All outputs are registered and reflect the sample taken on the same edge.
module ring_phase_monitor #(
  parameter int WIDTH     = 8,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_LIMIT = 3,
  parameter int ERR_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  ring_phase_if.slave  bus
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_chk_width
    $error("ring_phase_monitor: WIDTH must be a power of two >= 2");
  end
  if (LOCK_CNT < 1 || ERR_LIMIT < 1) begin : g_chk_limits
    $error("ring_phase_monitor: LOCK_CNT and ERR_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_LOCKING = 2'd1,
    S_LOCKED  = 2'd2,
    S_ALARM   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d, ref_rot;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [ERR_W-1:0] ec_q, ec_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             alarm_q, alarm_d;
  logic             pv_q, pv_d;
  logic             ep_q, ep_d;
  logic             onehot, step_ok;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // OR of indices of set bits: exact for one-hot, 0 for all-zero.
  function automatic logic [PW-1:0] encode(input logic [WIDTH-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = idx | PW'(i);
    return idx;
  endfunction

  assign ref_rot = {ref_q[WIDTH-2:0], ref_q[WIDTH-1]};
  assign onehot  = is_onehot(bus.cnt_in);
  assign step_ok = onehot && (bus.cnt_in == ref_rot);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_SEARCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH:
        if (bus.en && onehot) state_d = S_LOCKING;
      S_LOCKING:
        if (bus.en) begin
          if (!onehot)
            state_d = S_SEARCH;
          else if (step_ok && good_q == GW'(LOCK_CNT - 1))
            state_d = S_LOCKED;
        end
      S_LOCKED:
        if (bus.en && !step_ok && bad_q == BW'(ERR_LIMIT - 1))
          state_d = S_ALARM;
      S_ALARM:
        // clr_alarm wins over a coincident sample, which is discarded.
        if (bus.clr_alarm) state_d = S_SEARCH;
      default:
        state_d = S_SEARCH;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    ref_d  = ref_q;
    good_d = good_q;
    bad_d  = bad_q;
    ec_d   = ec_q;
    ep_d   = 1'b0;
    case (state_q)
      S_SEARCH:
        if (bus.en && onehot) begin
          ref_d  = bus.cnt_in;
          good_d = '0;
        end
      S_LOCKING:
        if (bus.en) begin
          if (step_ok) begin
            ref_d  = bus.cnt_in;
            good_d = good_q + GW'(1);
            bad_d  = '0;
          end else if (onehot) begin
            ref_d  = bus.cnt_in;
            good_d = '0;
          end
        end
      S_LOCKED:
        if (bus.en) begin
          if (step_ok) begin
            ref_d = bus.cnt_in;
            bad_d = '0;
          end else begin
            ep_d  = 1'b1;
            bad_d = bad_q + BW'(1);
            // Flywheel: assume the ring kept turning under the glitch.
            ref_d = ref_rot;
            if (ec_q != '1) ec_d = ec_q + ERR_W'(1);
          end
        end
      S_ALARM:
        if (bus.clr_alarm) begin
          good_d = '0;
          bad_d  = '0;
        end
      default: ;
    endcase
    locked_d = (state_d == S_LOCKED);
    alarm_d  = (state_d == S_ALARM);
    pv_d     = (state_d == S_LOCKING) || (state_d == S_LOCKED);
    phase_d  = encode(ref_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q    <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      ec_q     <= '0;
      phase_q  <= '0;
      locked_q <= 1'b0;
      alarm_q  <= 1'b0;
      pv_q     <= 1'b0;
      ep_q     <= 1'b0;
    end else begin
      ref_q    <= ref_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      ec_q     <= ec_d;
      phase_q  <= phase_d;
      locked_q <= locked_d;
      alarm_q  <= alarm_d;
      pv_q     <= pv_d;
      ep_q     <= ep_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.alarm       = alarm_q;
  assign bus.phase       = phase_q;
  assign bus.phase_valid = pv_q;
  assign bus.err_pulse   = ep_q;
  assign bus.err_count   = ec_q;
endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Downstream checker for the 8-bit one-hot ring counter output (`cnt`) in the safe-comm datapath.
- Samples the ring value and verifies two things: the value is one-hot, and each sample is exactly one left-rotation of the previous one (bit 7 wraps to bit 0).
- Runs a lock/alarm state machine, flywheels over isolated glitches, and reports phase index, error pulses and a saturating error count to the supervisor.

Parameters:
- WIDTH, 8, ring width; must be a power of two ≥ 2.
- LOCK_CNT, 4, consecutive legal steps in LOCKING required to declare lock (≥ 1).
- ERR_LIMIT, 3, consecutive bad samples in LOCKED that raise the alarm (≥ 1).
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; cnt_in is evaluated only on edges where en=1.
- cnt_in  input  WIDTH  ring counter value, connected to ring cnt.
- clr_alarm  input  1  leaves ALARM state; ignored in all other states.
- locked  output  1  1 while state = LOCKED.
- alarm  output  1  1 while state = ALARM.
- phase  output  log2(WIDTH)  bit index of the tracked reference value.
- phase_valid  output  1  1 in LOCKING and LOCKED.
- err_pulse  output  1  one-cycle pulse for each bad sample taken in LOCKED.
- err_count  output  ERR_W  saturating count of bad samples in LOCKED.

Behaviour:
- Reset: all outputs 0; state = SEARCH; ref = 0; good_run = 0; bad_run = 0. Reset takes effect immediately, without waiting for a clock edge.
- Latency: outputs are registered and reflect the sample taken on the same rising edge. Each output therefore updates one edge after cnt_in is presented.
- en=0: no state change, counters hold, err_pulse = 0.
- onehot = exactly one bit of cnt_in set.
- step_ok = onehot AND cnt_in == rotl1(ref), where rotl1 moves bit WIDTH-1 to bit 0. Example: 0x80 → 0x01 is legal.
- SEARCH:
  - onehot sample → LOCKING, with ref = cnt_in and good_run = 0.
  - Otherwise stay in SEARCH.
- LOCKING:
  - step_ok → ref = cnt_in, good_run += 1. When good_run reaches LOCK_CNT → LOCKED, with bad_run = 0.
  - Not step_ok but onehot → stay in LOCKING, ref = cnt_in, good_run = 0.
  - Not onehot → SEARCH.
- LOCKED:
  - step_ok → ref = cnt_in, bad_run = 0.
  - Bad sample:
    - err_pulse = 1.
    - err_count += 1, saturating at all-ones.
    - bad_run += 1.
    - ref = rotl1(ref): the flywheel advances, so one glitch costs only one error.
  - When bad_run reaches ERR_LIMIT → ALARM. The bad sample that triggers the alarm still produces err_pulse and increments err_count.
- ALARM:
  - Samples are ignored and err_count is frozen.
  - clr_alarm=1 → SEARCH, with good_run = 0, bad_run = 0 and ref held.
  - If clr_alarm and en are both 1 on the same edge, clr_alarm wins and the sample is discarded.
- phase = binary index of ref's set bit. phase is 0 when ref = 0.
- err_count is cleared only by rst; clr_alarm does not clear it.
- Reset mid-operation (any state): everything returns to the reset values above, and the sequence restarts from SEARCH.

Test Plan:
- Ring reset releases, ring value 0x01 then 0x02, 0x04, …, 0x80, 0x01, en=1:
  - First sample enters LOCKING.
  - locked=1 after the 5th sample (0x10).
  - phase tracks 0..7 and wraps 7→0.
  - err_count stays 0.
- LOCKED, inject one 0x03 in place of 0x08, then resume 0x10:
  - err_pulse=1 for exactly one cycle, err_count=1.
  - locked stays 1.
  - 0x10 is accepted through the flywheel, with no second error.
- LOCKED, inject 0x00 three times:
  - err_pulse on each, err_count=3.
  - alarm=1 and locked=0 after the third.
  - Further samples leave err_count at 3.
  - clr_alarm=1 → alarm=0, and a valid rotation relocks after 5 samples.
- Reverse rotation 0x80, 0x40, 0x20, … from SEARCH:
  - State stays in LOCKING with good_run reset each step.
  - locked never asserts.
- rst pulsed asynchronously (between clock edges) while LOCKED with err_count=2:
  - locked, phase_valid and err_count go to 0 before the next edge.
  - Relock requires 5 samples.
- Valid rotation with en toggled 1,0,0,1,… (ring held during gaps):
  - Identical lock timing counted in enabled samples.
  - No errors during en=0 cycles.
